// File: rtl/wd_drq_fifo.sv
// Sector-data FIFO between the STM32 stream and the Z80 WD1770 data register; sequences one LEN-byte transfer.
// Latency: MCU push visible on Z80_DOUT/DRQ next cycle; Z80 strobe edges act 3 cycles after the pin changes.
// Backpressure: MCU_IN_READY/MCU_OUT_VALID follow FIFO occupancy and LEN; WD1770_DRQ paces the Z80; over/underrun set LOST_DATA.
module wd_drq_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              CLK_16MHZ,
   input  logic              RST,
   input  logic              START,
   input  logic              ABORT,
   input  logic              DIR,
   input  logic [10:0]       LEN,
   input  logic [7:0]        MCU_IN_DATA,
   input  logic              MCU_IN_VALID,
   output logic              MCU_IN_READY,
   output logic [7:0]        MCU_OUT_DATA,
   output logic              MCU_OUT_VALID,
   input  logic              MCU_OUT_READY,
   input  logic              nDATA_RD,
   input  logic              nDATA_WR,
   input  logic [7:0]        Z80_DIN,
   output logic [7:0]        Z80_DOUT,
   output logic              Z80_DOE,
   output logic              WD1770_DRQ,
   output logic              BUSY,
   output logic              DONE,
   output logic              LOST_DATA,
   output logic [ADDR_W:0]   LEVEL
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

   localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

   state_t            state_q, state_d;
   logic [10:0]       len_q, len_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic [10:0]       mcu_cnt_q, mcu_cnt_d;
   logic [10:0]       z80_cnt_q, z80_cnt_d;
   logic              lost_q, lost_d;
   logic              drq_q, drq_d;
   logic [7:0]        dout_q, dout_d;
   logic [2:0]        rd_sync_q, rd_sync_d;
   logic [2:0]        wr_sync_q, wr_sync_d;
   logic [7:0]        mem_q [DEPTH];

   logic              full, empty, rd_rise, wr_fall;
   logic              push, pop;
   logic [7:0]        push_dat;

   assign full    = (level_q == FULL_LVL);
   assign empty   = (level_q == '0);
   // [0],[1] synchronise the pin, [2] holds the previous synchronised value for edge detection
   assign rd_rise = rd_sync_q[1] & ~rd_sync_q[2];
   assign wr_fall = ~wr_sync_q[1] & wr_sync_q[2];

   assign MCU_IN_READY  = (state_q == S_READ) && !full && (mcu_cnt_q < len_q);
   assign MCU_OUT_VALID = (state_q == S_WRITE) && !empty;
   assign MCU_OUT_DATA  = dout_q;
   assign Z80_DOUT      = dout_q;
   assign Z80_DOE       = ~nDATA_RD && (state_q == S_READ);
   assign WD1770_DRQ    = drq_q;
   assign BUSY          = (state_q != S_IDLE);
   assign DONE          = (state_q == S_DONE);
   assign LOST_DATA     = lost_q;
   assign LEVEL         = level_q;

   // Next-state: transfer sequencing, FIFO push/pop, counters, DRQ and head register
   always_comb begin
      rd_sync_d = {rd_sync_q[1:0], nDATA_RD};
      wr_sync_d = {wr_sync_q[1:0], nDATA_WR};
      state_d   = state_q;
      len_d     = len_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      mcu_cnt_d = mcu_cnt_q;
      z80_cnt_d = z80_cnt_q;
      lost_d    = lost_q;
      push      = 1'b0;
      pop       = 1'b0;
      push_dat  = MCU_IN_DATA;

      case (state_q)
         S_IDLE: begin
            if (START) begin
               // LEN==0 still passes through one active cycle with DRQ low, then completes
               state_d   = DIR ? S_WRITE : S_READ;
               len_d     = LEN;
               wr_ptr_d  = '0;
               rd_ptr_d  = '0;
               level_d   = '0;
               mcu_cnt_d = '0;
               z80_cnt_d = '0;
               lost_d    = 1'b0;
            end
         end
         S_READ: begin
            push = MCU_IN_VALID && MCU_IN_READY;
            if (rd_rise && (z80_cnt_q < len_q)) begin
               if (empty) lost_d = 1'b1;
               else       pop    = 1'b1;
            end
            if (push) mcu_cnt_d = mcu_cnt_q + 11'd1;
            if (pop)  z80_cnt_d = z80_cnt_q + 11'd1;
            if (z80_cnt_q == len_q) state_d = S_DONE;
         end
         S_WRITE: begin
            push_dat = Z80_DIN;
            pop      = MCU_OUT_VALID && MCU_OUT_READY;
            if (wr_fall && (z80_cnt_q < len_q)) begin
               if (full) lost_d = 1'b1;
               else      push   = 1'b1;
            end
            if (push) z80_cnt_d = z80_cnt_q + 11'd1;
            if (pop)  mcu_cnt_d = mcu_cnt_q + 11'd1;
            if (mcu_cnt_q == len_q) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase

      // ABORT wins over everything, including a START in the same cycle; LOST_DATA survives it
      if (ABORT) begin
         state_d   = S_IDLE;
         len_d     = len_q;
         push      = 1'b0;
         pop       = 1'b0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         level_d   = '0;
         mcu_cnt_d = '0;
         z80_cnt_d = '0;
         lost_d    = lost_q;
      end

      drq_d = 1'b0;
      if (state_d == S_READ)  drq_d = (level_d != '0) && (z80_cnt_d < len_d);
      if (state_d == S_WRITE) drq_d = (level_d != FULL_LVL) && (z80_cnt_d < len_d);

      // Head register follows the next head; a byte pushed into the head slot bypasses the array.
      // When the FIFO drains the last value is kept.
      dout_d = dout_q;
      if (level_d != '0) begin
         dout_d = (push && (rd_ptr_d == wr_ptr_q)) ? push_dat : mem_q[rd_ptr_d];
      end
   end

   // State and control registers with synchronous reset; strobe synchronisers idle high
   always_ff @(posedge CLK_16MHZ) begin
      if (RST) begin
         state_q   <= S_IDLE;
         len_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         mcu_cnt_q <= '0;
         z80_cnt_q <= '0;
         lost_q    <= 1'b0;
         drq_q     <= 1'b0;
         dout_q    <= 8'h00;
         rd_sync_q <= 3'b111;
         wr_sync_q <= 3'b111;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         mcu_cnt_q <= mcu_cnt_d;
         z80_cnt_q <= z80_cnt_d;
         lost_q    <= lost_d;
         drq_q     <= drq_d;
         dout_q    <= dout_d;
         rd_sync_q <= rd_sync_d;
         wr_sync_q <= wr_sync_d;
      end
   end

   // Storage array; contents need no reset since occupancy is tracked by the pointers
   always_ff @(posedge CLK_16MHZ) begin
      if (!RST && push) mem_q[wr_ptr_q] <= push_dat;
   end

endmodule

// File: tb/tb_wd_drq_fifo.sv
// Bench for wd_drq_fifo: scoreboarded read/write transfers, full/empty boundaries, over/underrun, ABORT/RST.
// Inputs driven 1 time unit after the rising edge; outputs sampled there too.
// Z80 strobes are 4 cycles low / 4 cycles high; MCU side driven cycle by cycle.
module tb_wd_drq_fifo;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              RST, START, ABORT, DIR;
   logic [10:0]       LEN;
   logic [7:0]        MCU_IN_DATA;
   logic              MCU_IN_VALID, MCU_IN_READY;
   logic [7:0]        MCU_OUT_DATA;
   logic              MCU_OUT_VALID, MCU_OUT_READY;
   logic              nDATA_RD, nDATA_WR;
   logic [7:0]        Z80_DIN, Z80_DOUT;
   logic              Z80_DOE, WD1770_DRQ, BUSY, DONE, LOST_DATA;
   logic [ADDR_W:0]   LEVEL;

   int                n_chk = 0;
   int                n_bad = 0;
   logic [7:0]        exp_q [$];
   logic              snap_rdy;
   logic [ADDR_W:0]   snap_lvl;

   wd_drq_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .CLK_16MHZ     (clk),
      .RST           (RST),
      .START         (START),
      .ABORT         (ABORT),
      .DIR           (DIR),
      .LEN           (LEN),
      .MCU_IN_DATA   (MCU_IN_DATA),
      .MCU_IN_VALID  (MCU_IN_VALID),
      .MCU_IN_READY  (MCU_IN_READY),
      .MCU_OUT_DATA  (MCU_OUT_DATA),
      .MCU_OUT_VALID (MCU_OUT_VALID),
      .MCU_OUT_READY (MCU_OUT_READY),
      .nDATA_RD      (nDATA_RD),
      .nDATA_WR      (nDATA_WR),
      .Z80_DIN       (Z80_DIN),
      .Z80_DOUT      (Z80_DOUT),
      .Z80_DOE       (Z80_DOE),
      .WD1770_DRQ    (WD1770_DRQ),
      .BUSY          (BUSY),
      .DONE          (DONE),
      .LOST_DATA     (LOST_DATA),
      .LEVEL         (LEVEL)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic start_xfer(input logic dir, input logic [10:0] len);
      DIR = dir;
      LEN = len;
      START = 1'b1;
      cyc();
      START = 1'b0;
   endtask

   task automatic mcu_offer(input logic [7:0] d, output bit acc);
      MCU_IN_DATA  = d;
      MCU_IN_VALID = 1'b1;
      acc = MCU_IN_READY;
      if (acc) exp_q.push_back(d);
      cyc();
      MCU_IN_VALID = 1'b0;
   endtask

   task automatic z80_rd(input bit exp_dat, input bit exp_doe);
      nDATA_RD = 1'b0;
      cyc();
      chk("z80_doe", Z80_DOE, exp_doe);
      if (exp_dat) begin
         if (exp_q.size() > 0) chk("z80_dout", Z80_DOUT, exp_q.pop_front());
         else                  chk("z80_sb_empty", exp_q.size(), 1);
      end
      repeat (3) cyc();
      nDATA_RD = 1'b1;
      repeat (3) cyc();
      snap_rdy = MCU_IN_READY;
      snap_lvl = LEVEL;
      cyc();
   endtask

   task automatic z80_wr(input logic [7:0] d, input bit exp_push);
      Z80_DIN = d;
      if (exp_push) exp_q.push_back(d);
      nDATA_WR = 1'b0;
      repeat (4) cyc();
      nDATA_WR = 1'b1;
      repeat (4) cyc();
   endtask

   task automatic mcu_drain(input int n, output int got);
      got = 0;
      MCU_OUT_READY = 1'b1;
      for (int i = 0; (i < 4*n + 4) && (got < n); i++) begin
         if (MCU_OUT_VALID) begin
            if (exp_q.size() > 0) chk("mcu_out", MCU_OUT_DATA, exp_q.pop_front());
            else                  chk("mcu_sb_empty", exp_q.size(), 1);
            got++;
         end
         cyc();
      end
      MCU_OUT_READY = 1'b0;
   endtask

   task automatic count_done(output int n);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         if (DONE) n++;
         cyc();
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: total=%0d bad=%0d", n_chk, n_bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit acc;
      int acc_tot;
      int n;

      RST = 1'b1; START = 1'b0; ABORT = 1'b0; DIR = 1'b0; LEN = '0;
      MCU_IN_DATA = '0; MCU_IN_VALID = 1'b0; MCU_OUT_READY = 1'b0;
      nDATA_RD = 1'b1; nDATA_WR = 1'b1; Z80_DIN = '0;
      repeat (3) cyc();
      RST = 1'b0;
      cyc();

      // Reset state
      chk("rst_busy",  BUSY, 0);
      chk("rst_done",  DONE, 0);
      chk("rst_drq",   WD1770_DRQ, 0);
      chk("rst_lost",  LOST_DATA, 0);
      chk("rst_level", LEVEL, 0);
      chk("rst_dout",  Z80_DOUT, 8'h00);
      chk("rst_irdy",  MCU_IN_READY, 0);
      chk("rst_ovld",  MCU_OUT_VALID, 0);
      chk("rst_doe",   Z80_DOE, 0);

      // Read transfer, LEN=4
      start_xfer(1'b0, 11'd4);
      chk("t1_busy", BUSY, 1);
      chk("t1_drq0", WD1770_DRQ, 0);
      chk("t1_irdy", MCU_IN_READY, 1);
      mcu_offer(8'h11, acc);
      chk("t1_acc", acc, 1);
      chk("t1_dout_vis", Z80_DOUT, 8'h11);
      chk("t1_drq_vis", WD1770_DRQ, 1);
      mcu_offer(8'h22, acc);
      chk("t1_acc", acc, 1);
      DIR = 1'b1; LEN = 11'd0; START = 1'b1;
      cyc();
      START = 1'b0;
      chk("t1_start_ign_busy", BUSY, 1);
      chk("t1_start_ign_lvl", LEVEL, 2);
      chk("t1_start_ign_irdy", MCU_IN_READY, 1);
      mcu_offer(8'h33, acc);
      chk("t1_acc", acc, 1);
      mcu_offer(8'h44, acc);
      chk("t1_acc", acc, 1);
      chk("t1_level4", LEVEL, 4);
      for (int i = 0; i < 4; i++) begin
         z80_rd(1'b1, 1'b1);
         chk("t1_drq_after_rd", WD1770_DRQ, (i < 3) ? 1 : 0);
      end
      count_done(n);
      chk("t1_done_cnt", n, 1);
      chk("t1_busy_end", BUSY, 0);
      chk("t1_lost", LOST_DATA, 0);

      // Write transfer, LEN=3, STM32 not ready until all three bytes are in
      start_xfer(1'b1, 11'd3);
      chk("t2_drq_start", WD1770_DRQ, 1);
      chk("t2_ovld0", MCU_OUT_VALID, 0);
      z80_wr(8'hA5, 1'b1);
      chk("t2_lvl1", LEVEL, 1);
      chk("t2_drq1", WD1770_DRQ, 1);
      z80_wr(8'h5A, 1'b1);
      chk("t2_lvl2", LEVEL, 2);
      chk("t2_drq2", WD1770_DRQ, 1);
      z80_wr(8'hFF, 1'b1);
      chk("t2_lvl3", LEVEL, 3);
      chk("t2_drq3", WD1770_DRQ, 0);
      chk("t2_ovld", MCU_OUT_VALID, 1);
      chk("t2_busy", BUSY, 1);
      mcu_drain(3, n);
      chk("t2_drain", n, 3);
      count_done(n);
      chk("t2_done_cnt", n, 1);
      chk("t2_busy_end", BUSY, 0);

      // Full boundary, read mode, LEN=20
      start_xfer(1'b0, 11'd20);
      acc_tot = 0;
      for (int i = 0; i < 18; i++) begin
         mcu_offer(8'(i + 1), acc);
         acc_tot += int'(acc);
      end
      chk("t3_acc16", acc_tot, 16);
      chk("t3_lvl16", LEVEL, 16);
      chk("t3_irdy_full", MCU_IN_READY, 0);
      chk("t3_drq", WD1770_DRQ, 1);
      z80_rd(1'b1, 1'b1);
      chk("t3_irdy_back", snap_rdy, 1);
      chk("t3_lvl15", snap_lvl, 15);
      for (int i = 0; i < 12; i++) begin
         mcu_offer(8'(8'h40 + i), acc);
         acc_tot += int'(acc);
         z80_rd(1'b1, 1'b1);
      end
      chk("t3_acc20", acc_tot, 20);
      chk("t3_irdy_len", MCU_IN_READY, 0);
      chk("t3_lvl7", LEVEL, 7);
      for (int i = 0; i < 7; i++) z80_rd(1'b1, 1'b1);
      count_done(n);
      chk("t3_done_cnt", n, 1);
      chk("t3_lvl0", LEVEL, 0);
      chk("t3_lost", LOST_DATA, 0);
      chk("t3_sb_left", exp_q.size(), 0);
      z80_rd(1'b0, 1'b0);
      chk("t3_idle_strobe_lost", LOST_DATA, 0);

      // Underrun, then overrun
      start_xfer(1'b0, 11'd2);
      z80_rd(1'b0, 1'b1);
      chk("t4_urun_lost", LOST_DATA, 1);
      chk("t4_urun_lvl", LEVEL, 0);
      mcu_offer(8'h5C, acc);
      chk("t4_acc", acc, 1);
      z80_rd(1'b1, 1'b1);
      chk("t4_lvl0", LEVEL, 0);
      count_done(n);
      chk("t4_no_done", n, 0);
      chk("t4_busy", BUSY, 1);
      ABORT = 1'b1;
      cyc();
      ABORT = 1'b0;
      chk("t4_abort_busy", BUSY, 0);
      chk("t4_abort_lost", LOST_DATA, 1);
      start_xfer(1'b1, 11'd20);
      chk("t4_start_clr", LOST_DATA, 0);
      for (int i = 0; i < 16; i++) z80_wr(8'(8'h80 + i), 1'b1);
      chk("t4_lvl16", LEVEL, 16);
      chk("t4_drq_full", WD1770_DRQ, 0);
      z80_wr(8'hEE, 1'b0);
      chk("t4_orun_lost", LOST_DATA, 1);
      chk("t4_orun_lvl", LEVEL, 16);
      mcu_drain(16, n);
      chk("t4_drain", n, 16);
      chk("t4_lvl_drained", LEVEL, 0);
      chk("t4_sb_left", exp_q.size(), 0);
      ABORT = 1'b1;
      cyc();
      ABORT = 1'b0;

      // Simultaneous push/pop at LEVEL=1 (write mode)
      start_xfer(1'b1, 11'd2);
      chk("t5_lost_clr", LOST_DATA, 0);
      z80_wr(8'hC1, 1'b1);
      chk("t5_lvl1", LEVEL, 1);
      Z80_DIN = 8'hC2;
      exp_q.push_back(8'hC2);
      nDATA_WR = 1'b0;
      cyc();
      cyc();
      chk("t5_head", MCU_OUT_DATA, exp_q.pop_front());
      MCU_OUT_READY = 1'b1;
      cyc();
      MCU_OUT_READY = 1'b0;
      chk("t5_lvl_same", LEVEL, 1);
      cyc();
      nDATA_WR = 1'b1;
      repeat (4) cyc();
      mcu_drain(1, n);
      chk("t5_drain", n, 1);
      count_done(n);
      chk("t5_done_cnt", n, 1);

      // LEN=0
      start_xfer(1'b1, 11'd0);
      chk("t6_done_c1", DONE, 0);
      chk("t6_drq_c1", WD1770_DRQ, 0);
      cyc();
      chk("t6_done_c2", DONE, 1);
      chk("t6_drq_c2", WD1770_DRQ, 0);
      cyc();
      chk("t6_done_c3", DONE, 0);
      chk("t6_busy_c3", BUSY, 0);

      // ABORT at LEVEL=5 with LOST_DATA set
      start_xfer(1'b0, 11'd10);
      z80_rd(1'b0, 1'b1);
      for (int i = 0; i < 5; i++) mcu_offer(8'(8'hD0 + i), acc);
      chk("t7_lvl5", LEVEL, 5);
      chk("t7_drq", WD1770_DRQ, 1);
      ABORT = 1'b1;
      cyc();
      ABORT = 1'b0;
      exp_q.delete();
      chk("t7_abort_busy", BUSY, 0);
      chk("t7_abort_lvl", LEVEL, 0);
      chk("t7_abort_drq", WD1770_DRQ, 0);
      chk("t7_abort_lost", LOST_DATA, 1);
      count_done(n);
      chk("t7_abort_no_done", n, 0);

      // RST at LEVEL=5 with LOST_DATA set
      start_xfer(1'b0, 11'd10);
      chk("t7_start_clr", LOST_DATA, 0);
      z80_rd(1'b0, 1'b1);
      for (int i = 0; i < 5; i++) mcu_offer(8'(8'hE0 + i), acc);
      chk("t7_lvl5b", LEVEL, 5);
      RST = 1'b1;
      cyc();
      RST = 1'b0;
      exp_q.delete();
      chk("t7_rst_busy", BUSY, 0);
      chk("t7_rst_lvl", LEVEL, 0);
      chk("t7_rst_drq", WD1770_DRQ, 0);
      chk("t7_rst_lost", LOST_DATA, 0);
      chk("t7_rst_dout", Z80_DOUT, 8'h00);
      count_done(n);
      chk("t7_rst_no_done", n, 0);

      // Clean single-byte transfer after reset
      start_xfer(1'b0, 11'd1);
      mcu_offer(8'h9D, acc);
      chk("t8_acc", acc, 1);
      z80_rd(1'b1, 1'b1);
      count_done(n);
      chk("t8_done_cnt", n, 1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
